wff_graph_loader: RTL and testbench
===================================

// Module: wff_graph_loader
// PURPOSE
//  Streams initial node records (excess, wave, 4 capacities, flags) into the per-layer node RAMs of p_wff
//  before a solve; write-side counterpart of the post-finish e_r_sink read-out.
//  Generates layer/address for raster order (x fastest, then y, then z) and sums positive excess into init_flow.
//  Sits between host/DMA stream and the p_wff layer RAM write ports.
// PARAMETERS
//  X 129 grid width | Y 129 grid height | Z 16 layers
//  EX_WIDTH 14 signed excess | WV_WIDTH 10 wave | CF_WIDTH 10 per-edge capacity
//  MF_WIDTH 22 flow accumulator | DATA_WIDTH EX_WIDTH+WV_WIDTH+4*CF_WIDTH+8 record width
// PORTS
//  clk        in   1            clock
//  rst        in   1            reset, synchronous, active-high
//  start      in   1            pulse: begin load (ignored while busy)
//  s_valid    in   1            record valid
//  s_ready    out  1            record accepted when s_valid&&s_ready
//  s_data     in   DATA_WIDTH   record; excess = s_data[DATA_WIDTH-1 -: EX_WIDTH]
//  s_last     in   1            marks final record of frame
//  wr_en      out  1            layer RAM write strobe
//  wr_layer   out  log2(Z)      target layer z
//  wr_addr    out  log2(X*Y)    in-layer address y*X+x
//  wr_data    out  DATA_WIDTH   record, unmodified
//  init_flow  out  MF_WIDTH     sum of positive excess, valid when done
//  busy       out  1            high in LOAD
//  done       out  1            1-cycle pulse after last write
//  err        out  1            sticky framing error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-load abandons the frame; no done.
//  FSM IDLE -> LOAD on start (clear xy/z counters, init_flow, err) -> FIN after the final accept -> IDLE.
//  s_ready = (state==LOAD); no write-side backpressure; 1 accept/cycle max.
//  Latency: accept at cycle t -> wr_en/wr_layer/wr_addr/wr_data registered at t+1.
//  Counters: xy 0..X*Y-1 wraps to 0 with z+1; record with xy==X*Y-1, z==Z-1 is final.
//  FIN: one cycle, after the final wr_en; done=1, busy=0; init_flow stable until next start.
//  init_flow += sext(excess) only when excess[EX_WIDTH-1]==0; modulo 2^MF_WIDTH, no saturation.
//  start in LOAD/FIN ignored; start and rst together: rst wins.
//  s_valid low: no counter movement, wr_en=0 next cycle.
// CONFIGURATION
//  WFF_LOADER_CHECK_EN defined: s_last on a non-final record sets err, aborts to IDLE, no done.
//   Final record without s_last sets err; load still completes with done.
//  Not defined: s_last ignored; err tied 0; length fixed by X*Y*Z only.
// STRUCTURE
//  wff_pkg: EX/WV/CF/MF widths, DATA_WIDTH, field offsets, log2 function, FSM state enum.
//  Sub-module wff_loader_addr_gen: xy/z counter pair with advance, clear and final flags.
//  Top: FSM, output registers, accumulator, check logic.
// TESTING (X=3,Y=2,Z=2, 12 records)
//  Full frame, excess 5,-3,0,7,... continuous valid -> 12 writes, addr 0..5 layer 0 then 0..5 layer 1; done 1 cycle after last write.
//  All excess +10 -> init_flow=120; all -1 -> init_flow=0.
//  s_valid toggled 1/0 -> writes only after accepts, order unchanged, done after 12th write.
//  CHECK_EN: s_last on record 5 -> err=1, busy=0, no done; next start clears err.
//  rst asserted after record 4 -> outputs 0 next cycle; new start reloads from addr 0 layer 0.
//  start pulsed during LOAD -> ignored; counters unaffected.

Source files
------------

// File: rtl/wff_pkg.sv
// rtl/wff_pkg.sv - shared widths, record field offsets, log2 helper and FSM state for the wff graph loader
package wff_pkg;

    localparam int EX_WIDTH   = 14;
    localparam int WV_WIDTH   = 10;
    localparam int CF_WIDTH   = 10;
    localparam int MF_WIDTH   = 22;
    localparam int FLAG_WIDTH = 8;
    localparam int DATA_WIDTH = EX_WIDTH + WV_WIDTH + 4*CF_WIDTH + FLAG_WIDTH;

    // Record layout, MSB first: excess | wave | 4 capacities | flags
    localparam int EX_LSB   = DATA_WIDTH - EX_WIDTH;
    localparam int WV_LSB   = EX_LSB - WV_WIDTH;
    localparam int CF_LSB   = FLAG_WIDTH;
    localparam int FLAG_LSB = 0;

    // Ceiling log2, never below 1 so single-entry dimensions still get a port bit
    function automatic int log2c(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/wff_loader_addr_gen.sv
// rtl/wff_loader_addr_gen.sv - raster xy/z counter pair producing layer RAM addresses and the final-record flag
module wff_loader_addr_gen #(
    parameter int X  = 129,
    parameter int Y  = 129,
    parameter int Z  = 16,
    parameter int AW = 15,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] xy,
    output logic [LW-1:0] z,
    output logic          is_final
);

    localparam logic [AW-1:0] XY_LAST = AW'(X*Y - 1);
    localparam logic [LW-1:0] Z_LAST  = LW'(Z - 1);

    assign is_final = (xy == XY_LAST) && (z == Z_LAST);

    // xy runs fastest; on its wrap the layer index steps, and the whole pair wraps after the final record
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            xy <= '0;
            z  <= '0;
        end else if (advance) begin
            if (xy == XY_LAST) begin
                xy <= '0;
                z  <= (z == Z_LAST) ? '0 : z + 1'b1;
            end else begin
                xy <= xy + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wff_graph_loader.sv
// rtl/wff_graph_loader.sv - streams node records into p_wff layer RAMs and sums positive excess; WFF_LOADER_CHECK_EN enables s_last framing checks
module wff_graph_loader
    import wff_pkg::*;
#(
    parameter int X = 129,
    parameter int Y = 129,
    parameter int Z = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_last,
    output logic                      wr_en,
    output logic [log2c(Z)-1:0]       wr_layer,
    output logic [log2c(X*Y)-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [MF_WIDTH-1:0]       init_flow,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int LW = log2c(Z);
    localparam int AW = log2c(X*Y);

    state_t               state;
    logic [AW-1:0]        xy;
    logic [LW-1:0]        z;
    logic                 is_final;
    logic                 accept;
    logic                 ctr_clear;
    logic [EX_WIDTH-1:0]  excess;
    logic [MF_WIDTH-1:0]  excess_ext;

    assign s_ready    = (state == ST_LOAD);
    assign accept     = s_ready && s_valid;
    assign ctr_clear  = (state == ST_IDLE) && start;
    assign excess     = s_data[EX_LSB +: EX_WIDTH];
    assign excess_ext = {{(MF_WIDTH-EX_WIDTH){excess[EX_WIDTH-1]}}, excess};

`ifndef WFF_LOADER_CHECK_EN
    logic unused_last;
    assign unused_last = s_last;
`endif

    wff_loader_addr_gen #(
        .X  (X),
        .Y  (Y),
        .Z  (Z),
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .advance  (accept),
        .xy       (xy),
        .z        (z),
        .is_final (is_final)
    );

    // Load FSM: registered write port, excess accumulator, framing error and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_en     <= 1'b0;
            wr_layer  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_flow <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        busy      <= 1'b1;
                        init_flow <= '0;
                        err       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        wr_en    <= 1'b1;
                        wr_layer <= z;
                        wr_addr  <= xy;
                        wr_data  <= s_data;
                        // Only sources (non-negative excess) contribute; sinks are skipped, sum wraps
                        if (!excess[EX_WIDTH-1])
                            init_flow <= init_flow + excess_ext;
`ifdef WFF_LOADER_CHECK_EN
                        if (s_last && !is_final) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (is_final) begin
                            if (!s_last)
                                err <= 1'b1;
                            state <= ST_FIN;
                            busy  <= 1'b0;
                        end
`else
                        if (is_final) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wff_graph_loader.sv
// tb/tb_wff_graph_loader.sv - scoreboard bench for wff_graph_loader on a 3x2x2 grid
module tb_wff_graph_loader;
    import wff_pkg::*;

    localparam int NX = 3;
    localparam int NY = 2;
    localparam int NZ = 2;
    localparam int NREC = NX*NY*NZ;

    typedef struct {
        int              layer;
        int              addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_exp_t;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  wr_en;
    logic [0:0]            wr_layer;
    logic [2:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [MF_WIDTH-1:0]   init_flow;
    logic                  busy;
    logic                  done;
    logic                  err;

    int total = 0;
    int bad   = 0;
    wr_exp_t sb[$];
    int model_flow;

    wff_graph_loader #(.X(NX), .Y(NY), .Z(NZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wr_en     (wr_en),
        .wr_layer  (wr_layer),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_flow (init_flow),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the oldest accepted record
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", 1, 0);
            end else begin
                wr_exp_t e;
                e = sb.pop_front();
                check("wr_layer", 128'(wr_layer), 128'(e.layer));
                check("wr_addr",  128'(wr_addr),  128'(e.addr));
                check("wr_data",  128'(wr_data),  128'(e.data));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one record until accepted; idx fixes the expected raster position
    task automatic send_rec(input int idx, input int ex, input bit last, input bit gap);
        logic [63:0] r;
        logic [DATA_WIDTH-1:0] d;
        logic [EX_WIDTH-1:0] exv;
        bit ok;
        int tries;
        r   = {$urandom, $urandom};
        exv = EX_WIDTH'(ex);
        d   = {exv, r[DATA_WIDTH-EX_WIDTH-1:0]};
        if (gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        tries   = 0;
        ok      = 1'b0;
        while (!ok && tries < 20) begin
            ok = s_ready;
            if (ok) begin
                wr_exp_t e;
                e.layer = idx / (NX*NY);
                e.addr  = idx % (NX*NY);
                e.data  = d;
                sb.push_back(e);
                if (ex >= 0) model_flow += ex;
            end
            @(posedge clk); #1;
            tries++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input int ex[NREC], input bit gap, input bit start_mid, input bit omit_last);
        int n;
        model_flow = 0;
        pulse_start();
        check("busy_load", busy, 1);
        check("ready_load", s_ready, 1);
        for (int i = 0; i < NREC; i++) begin
            if (start_mid && i == 3) start = 1'b1;
            send_rec(i, ex[i], (i == NREC-1) && !omit_last, gap);
            start = 1'b0;
            if (start_mid && i == 3) check("busy_after_start_mid", busy, 1);
        end
        check("busy_fin", busy, 0);
        check("wr_last", wr_en, 1);
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_latency", n, 1);
        check("init_flow", 128'(init_flow), 128'(model_flow % (1 << MF_WIDTH)));
`ifdef WFF_LOADER_CHECK_EN
        check("err_frame", err, omit_last);
`else
        check("err_frame", err, 0);
`endif
        check("sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("ready_idle", s_ready, 0);
    endtask

    initial begin
        int ex[NREC];
        int pat[NREC] = '{5, -3, 0, 7, 2, -8, 1, 0, -1, 4, 9, -5};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_flow", 128'(init_flow), 0);
        check("rst_ready", s_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // mixed-sign excess, continuous valid
        run_frame(pat, 1'b0, 1'b0, 1'b0);

        // all +10 and all -1
        foreach (ex[i]) ex[i] = 10;
        run_frame(ex, 1'b0, 1'b0, 1'b0);
        foreach (ex[i]) ex[i] = -1;
        run_frame(ex, 1'b0, 1'b0, 1'b0);

        // extreme excess values
        foreach (ex[i]) ex[i] = (i % 2) ? -8192 : 8191;
        run_frame(ex, 1'b0, 1'b0, 1'b0);

        // toggled valid and a start pulse mid-load
        run_frame(pat, 1'b1, 1'b1, 1'b0);

        // reset after record 4, then a clean reload from address 0
        model_flow = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_rec(i, 6, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_flow", 128'(init_flow), 0);
        check("midrst_ready", s_ready, 0);
        check("midrst_addr", 128'(wr_addr), 0);
        check("midrst_sb", sb.size(), 0);
        sb.delete();
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst_no_done", done, 0);
        end
        run_frame(pat, 1'b0, 1'b0, 1'b0);

`ifdef WFF_LOADER_CHECK_EN
        // early s_last aborts without done
        model_flow = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) send_rec(i, 1, (i == 4), 1'b0);
        check("abort_err", err, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", s_ready, 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
        end
        check("abort_sb", sb.size(), 0);
        pulse_start();
        check("start_clears_err", err, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        // missing s_last on final record: err but still done
        run_frame(pat, 1'b0, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
